// File: rtl/uart_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_ctrl_pkg
// Description : Shared types and default constants for the UART transmit
//               arbiter. Holds the FSM state encoding and the default
//               requester count and transfer timeout.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_ctrl_pkg;

    localparam int c_NREQ_DEFAULT        = 4;
    localparam int c_TIMEOUT_CYC_DEFAULT = 1_000_000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        RELEASE   = 2'd3
    } state_t;

endpackage : uart_ctrl_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin selector. Searches the request
//               vector starting at the index after i_pointer, wrapping
//               around, and returns the first active requester one-hot.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_pointer,
    output logic [NREQ-1:0] o_winner
);

    // One extra bit so pointer + offset never overflows before the wrap.
    logic [PW:0]   w_sum;
    logic [PW-1:0] w_idx;
    logic          w_found;

    // Walk offsets 1..NREQ from the pointer; the pointer itself is checked last.
    always_comb begin
        o_winner = '0;
        w_found  = 1'b0;
        w_sum    = '0;
        w_idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_sum = {1'b0, i_pointer} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(NREQ)) begin
                w_sum = w_sum - (PW+1)'(NREQ);
            end
            w_idx = w_sum[PW-1:0];
            if (!w_found && i_req[w_idx]) begin
                o_winner[w_idx] = 1'b1;
                w_found         = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one UART transmitter among NREQ requesters. Picks an
//               owner round-robin, launches its byte, waits for tx_done (or
//               a timeout), acknowledges the owner and releases the bus.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NREQ        = c_NREQ_DEFAULT,
    parameter int TIMEOUT_CYC = c_TIMEOUT_CYC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   req_ack,
    output logic              tx_send_en,
    output logic [7:0]        tx_data_byte,
    input  logic              tx_done,
    output logic              timeout_err
);

    localparam int            PW        = $clog2(NREQ);
    localparam int            CW        = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CW-1:0] c_TERM    = CW'(TIMEOUT_CYC - 1);
    // Pointer resets to the last index so index 0 is searched first.
    localparam logic [PW-1:0] c_PTR_RST = PW'(NREQ - 1);

    state_t        r_state,  w_state_nxt;
    logic [NREQ-1:0] r_grant, w_grant_nxt;
    logic [NREQ-1:0] r_ack,   w_ack_nxt;
    logic          r_send,   w_send_nxt;
    logic [7:0]    r_byte,   w_byte_nxt;
    logic          r_err,    w_err_nxt;
    logic [PW-1:0] r_ptr,    w_ptr_nxt;
    logic [CW-1:0] r_cnt,    w_cnt_nxt;

    logic [NREQ-1:0] w_winner;
    logic [PW-1:0]   w_win_idx;
    logic [7:0]      w_win_byte;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_arbiter (
        .i_req     (req),
        .i_pointer (r_ptr),
        .o_winner  (w_winner)
    );

    // Encode the one-hot winner and select its byte.
    always_comb begin
        w_win_idx  = '0;
        w_win_byte = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner[i]) begin
                w_win_idx  = PW'(i);
                w_win_byte = req_data[8*i +: 8];
            end
        end
    end

    // Next-state and next-output logic; pulses default low, holds default to current.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ack_nxt   = '0;
        w_send_nxt  = 1'b0;
        w_byte_nxt  = r_byte;
        w_err_nxt   = 1'b0;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_state_nxt = LAUNCH;
                    w_grant_nxt = w_winner;
                    w_byte_nxt  = w_win_byte;
                    w_send_nxt  = 1'b1;
                    w_ptr_nxt   = w_win_idx;
                end
            end
            LAUNCH: begin
                w_state_nxt = WAIT_DONE;
                w_cnt_nxt   = '0;
            end
            WAIT_DONE: begin
                // A completion on the terminal cycle still counts as success.
                if (tx_done) begin
                    w_ack_nxt   = r_grant;
                    w_grant_nxt = '0;
                    w_state_nxt = RELEASE;
                end else if (r_cnt == c_TERM) begin
                    w_err_nxt   = 1'b1;
                    w_grant_nxt = '0;
                    w_state_nxt = RELEASE;
                end else begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                end
            end
            RELEASE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transfer silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ack   <= '0;
            r_send  <= 1'b0;
            r_byte  <= 8'h00;
            r_err   <= 1'b0;
            r_ptr   <= c_PTR_RST;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ack   <= w_ack_nxt;
            r_send  <= w_send_nxt;
            r_byte  <= w_byte_nxt;
            r_err   <= w_err_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign grant        = r_grant;
    assign req_ack      = r_ack;
    assign tx_send_en   = r_send;
    assign tx_data_byte = r_byte;
    assign timeout_err  = r_err;

endmodule : uart_tx_arbiter
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter (NREQ=4,
//               TIMEOUT_CYC=16). Expected launches are queued when requests
//               are driven and popped when the arbiter launches a byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int TO   = 16;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic [3:0]  req      = '0;
    logic [31:0] req_data = '0;
    logic        tx_done  = 1'b0;
    logic [3:0]  grant;
    logic [3:0]  req_ack;
    logic        tx_send_en;
    logic [7:0]  tx_data_byte;
    logic        timeout_err;

    int vectors     = 0;
    int miscompares = 0;
    int n_ack       = 0;
    int n_err       = 0;
    int n_launch    = 0;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];

    uart_tx_arbiter #(
        .NREQ        (NREQ),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_data     (req_data),
        .grant        (grant),
        .req_ack      (req_ack),
        .tx_send_en   (tx_send_en),
        .tx_data_byte (tx_data_byte),
        .tx_done      (tx_done),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (req_ack != 4'b0000) n_ack <= n_ack + 1;
        if (timeout_err === 1'b1) n_err <= n_err + 1;
        if (tx_send_en === 1'b1) n_launch <= n_launch + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int idx, input logic [7:0] data);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic wait_launch(input int budget, output int cycles, output bit ok);
        ok     = 1'b0;
        cycles = 0;
        while (!ok && cycles < budget) begin
            tick();
            cycles++;
            if (tx_send_en === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++; if (grant !== 4'b0000)     begin miscompares++; $display("FAIL reset_grant: got %b want 0000", grant); end
        vectors++; if (req_ack !== 4'b0000)   begin miscompares++; $display("FAIL reset_ack: got %b want 0000", req_ack); end
        vectors++; if (tx_send_en !== 1'b0)   begin miscompares++; $display("FAIL reset_send: got %b want 0", tx_send_en); end
        vectors++; if (tx_data_byte !== 8'h00) begin miscompares++; $display("FAIL reset_byte: got %h want 00", tx_data_byte); end
        vectors++; if (timeout_err !== 1'b0)  begin miscompares++; $display("FAIL reset_err: got %b want 0", timeout_err); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int cyc; bit ok; exp_t e; logic [3:0] oh; int a0; int l0;
        req_data[15:8] = 8'hA5;
        req            = 4'b0010;
        push_exp(1, 8'hA5);
        wait_launch(1, cyc, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL single_latency: got no launch at N+1 want launch"); end
        e  = sb.pop_front();
        oh = 4'b0001 << e.idx;
        vectors++; if (grant !== oh)          begin miscompares++; $display("FAIL single_grant: got %b want %b", grant, oh); end
        vectors++; if (tx_data_byte !== e.data) begin miscompares++; $display("FAIL single_byte: got %h want %h", tx_data_byte, e.data); end
        tick();
        vectors++; if (tx_send_en !== 1'b0)   begin miscompares++; $display("FAIL single_send_width: got %b want 0", tx_send_en); end
        vectors++; if (tx_data_byte !== e.data) begin miscompares++; $display("FAIL single_byte_hold: got %h want %h", tx_data_byte, e.data); end
        tick();
        a0 = n_ack;
        l0 = n_launch;
        pulse_done();
        vectors++; if (req_ack !== oh)        begin miscompares++; $display("FAIL single_ack: got %b want %b", req_ack, oh); end
        vectors++; if (grant !== 4'b0000)     begin miscompares++; $display("FAIL single_grant_clr: got %b want 0000", grant); end
        req = 4'b0000;
        tick();
        vectors++; if (req_ack !== 4'b0000)   begin miscompares++; $display("FAIL single_ack_width: got %b want 0000", req_ack); end
        repeat (4) tick();
        vectors++; if (n_ack - a0 != 1)       begin miscompares++; $display("FAIL single_ack_count: got %0d want 1", n_ack - a0); end
        vectors++; if (n_launch != l0)        begin miscompares++; $display("FAIL single_extra_launch: got %0d want 0", n_launch - l0); end
    endtask

    task automatic test_round_robin();
        int cyc; bit ok; exp_t e; logic [3:0] oh;
        do_reset();
        req_data = 32'h13121110;
        req      = 4'b1111;
        push_exp(0, 8'h10); push_exp(1, 8'h11); push_exp(2, 8'h12);
        push_exp(3, 8'h13); push_exp(0, 8'h10);
        for (int t = 0; t < 5; t++) begin
            wait_launch(40, cyc, ok);
            vectors++; if (!ok) begin miscompares++; $display("FAIL rr_launch_timeout: launch %0d got none want launch", t); end
            if (t > 0) begin
                vectors++; if (cyc != 2) begin miscompares++; $display("FAIL rr_gap: launch %0d got %0d edges after ack want 2", t, cyc); end
            end
            e  = sb.pop_front();
            oh = 4'b0001 << e.idx;
            vectors++; if (grant !== oh)            begin miscompares++; $display("FAIL rr_grant: launch %0d got %b want %b", t, grant, oh); end
            vectors++; if (tx_data_byte !== e.data) begin miscompares++; $display("FAIL rr_byte: launch %0d got %h want %h", t, tx_data_byte, e.data); end
            tick();
            tick();
            pulse_done();
            vectors++; if (req_ack !== oh)          begin miscompares++; $display("FAIL rr_ack: launch %0d got %b want %b", t, req_ack, oh); end
            if (t == 4) req = 4'b0000;
        end
        repeat (3) tick();
    endtask

    task automatic test_timeout();
        int cyc; bit ok; exp_t e; logic [3:0] oh; int a0; int e0; int k; bit found;
        do_reset();
        req_data = 32'h00770055;
        req      = 4'b0101;
        push_exp(0, 8'h55);
        push_exp(2, 8'h77);
        wait_launch(40, cyc, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL to_launch: got none want launch"); end
        e  = sb.pop_front();
        oh = 4'b0001 << e.idx;
        vectors++; if (grant !== oh) begin miscompares++; $display("FAIL to_grant: got %b want %b", grant, oh); end
        a0 = n_ack;
        e0 = n_err;
        k = 0; found = 1'b0;
        while (!found && k < 40) begin
            tick();
            k++;
            if (timeout_err === 1'b1) found = 1'b1;
        end
        vectors++; if (!found || k != 17) begin miscompares++; $display("FAIL to_latency: got err at edge %0d (seen %b) want 17", k, found); end
        vectors++; if (grant !== 4'b0000)   begin miscompares++; $display("FAIL to_grant_clr: got %b want 0000", grant); end
        vectors++; if (req_ack !== 4'b0000) begin miscompares++; $display("FAIL to_no_ack: got %b want 0000", req_ack); end
        wait_launch(40, cyc, ok);
        vectors++; if (!ok || cyc != 2) begin miscompares++; $display("FAIL to_next_launch: got %0d edges (ok %b) want 2", cyc, ok); end
        e  = sb.pop_front();
        oh = 4'b0001 << e.idx;
        vectors++; if (grant !== oh)            begin miscompares++; $display("FAIL to_next_grant: got %b want %b", grant, oh); end
        vectors++; if (tx_data_byte !== e.data) begin miscompares++; $display("FAIL to_next_byte: got %h want %h", tx_data_byte, e.data); end
        tick();
        vectors++; if (n_err - e0 != 1) begin miscompares++; $display("FAIL to_err_count: got %0d want 1", n_err - e0); end
        vectors++; if (n_ack != a0)     begin miscompares++; $display("FAIL to_ack_count: got %0d want 0", n_ack - a0); end
        tick();
        pulse_done();
        vectors++; if (req_ack !== oh)  begin miscompares++; $display("FAIL to_next_ack: got %b want %b", req_ack, oh); end
        req = 4'b0000;
        repeat (3) tick();
    endtask

    task automatic test_coincide();
        int cyc; bit ok; exp_t e; logic [3:0] oh; int e0;
        do_reset();
        req_data = 32'h0000003C;
        req      = 4'b0001;
        push_exp(0, 8'h3C);
        wait_launch(40, cyc, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL co_launch: got none want launch"); end
        e  = sb.pop_front();
        oh = 4'b0001 << e.idx;
        vectors++; if (tx_data_byte !== e.data) begin miscompares++; $display("FAIL co_byte: got %h want %h", tx_data_byte, e.data); end
        e0 = n_err;
        repeat (16) tick();
        pulse_done();
        vectors++; if (req_ack !== oh)      begin miscompares++; $display("FAIL co_ack: got %b want %b", req_ack, oh); end
        vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL co_err: got %b want 0", timeout_err); end
        req = 4'b0000;
        repeat (3) tick();
        vectors++; if (n_err != e0) begin miscompares++; $display("FAIL co_err_count: got %0d want 0", n_err - e0); end
    endtask

    task automatic test_reset_mid();
        int cyc; bit ok; exp_t e; logic [3:0] oh; int a0; int e0;
        req_data = 32'h9E000000;
        req      = 4'b1000;
        push_exp(3, 8'h9E);
        wait_launch(40, cyc, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rm_launch: got none want launch"); end
        e  = sb.pop_front();
        oh = 4'b0001 << e.idx;
        vectors++; if (grant !== oh) begin miscompares++; $display("FAIL rm_grant: got %b want %b", grant, oh); end
        tick();
        tick();
        a0 = n_ack;
        e0 = n_err;
        rst = 1'b1;
        #1;
        vectors++; if (grant !== 4'b0000)      begin miscompares++; $display("FAIL rm_async_grant: got %b want 0000", grant); end
        vectors++; if (tx_data_byte !== 8'h00) begin miscompares++; $display("FAIL rm_async_byte: got %h want 00", tx_data_byte); end
        tick();
        tick();
        rst = 1'b0;
        push_exp(3, 8'h9E);
        wait_launch(1, cyc, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rm_relaunch: got none at N+1 want launch"); end
        e  = sb.pop_front();
        oh = 4'b0001 << e.idx;
        vectors++; if (grant !== oh)            begin miscompares++; $display("FAIL rm_regrant: got %b want %b", grant, oh); end
        vectors++; if (tx_data_byte !== e.data) begin miscompares++; $display("FAIL rm_rebyte: got %h want %h", tx_data_byte, e.data); end
        vectors++; if (n_ack != a0 || n_err != e0) begin miscompares++; $display("FAIL rm_stray: got ack %0d err %0d want 0 0", n_ack - a0, n_err - e0); end
        tick();
        tick();
        pulse_done();
        vectors++; if (req_ack !== oh) begin miscompares++; $display("FAIL rm_ack: got %b want %b", req_ack, oh); end
        req = 4'b0000;
        repeat (3) tick();
    endtask

    task automatic test_drop_and_stray();
        int cyc; bit ok; exp_t e; logic [3:0] oh; int a0; int e0; int l0;
        a0 = n_ack;
        e0 = n_err;
        l0 = n_launch;
        pulse_done();
        vectors++; if (req_ack !== 4'b0000) begin miscompares++; $display("FAIL stray_ack: got %b want 0000", req_ack); end
        vectors++; if (grant !== 4'b0000)   begin miscompares++; $display("FAIL stray_grant: got %b want 0000", grant); end
        tick();
        tick();
        vectors++; if (n_ack != a0 || n_err != e0 || n_launch != l0) begin
            miscompares++;
            $display("FAIL stray_counts: got ack %0d err %0d launch %0d want 0 0 0", n_ack - a0, n_err - e0, n_launch - l0);
        end
        req_data = 32'h00C30000;
        req      = 4'b0100;
        push_exp(2, 8'hC3);
        wait_launch(1, cyc, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL drop_launch: got none at N+1 want launch"); end
        e  = sb.pop_front();
        oh = 4'b0001 << e.idx;
        vectors++; if (tx_data_byte !== e.data) begin miscompares++; $display("FAIL drop_byte: got %h want %h", tx_data_byte, e.data); end
        tick();
        req = 4'b0000;
        tick();
        tick();
        pulse_done();
        vectors++; if (req_ack !== oh)      begin miscompares++; $display("FAIL drop_ack: got %b want %b", req_ack, oh); end
        tick();
        vectors++; if (req_ack !== 4'b0000) begin miscompares++; $display("FAIL drop_ack_width: got %b want 0000", req_ack); end
        vectors++; if (grant !== 4'b0000)   begin miscompares++; $display("FAIL drop_grant: got %b want 0000", grant); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_coincide();
        test_reset_mid();
        test_drop_and_stray();
        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_uart_tx_arbiter
`default_nettype wire
